// File: rtl/frame_sequencer.sv
// Frame sequencer: header beats, Y/C quant matrices, slice data, flush.
// Optional bit accumulator on total_bits: define FRAME_SEQ_BITCOUNT_EN.
module frame_sequencer #(
  parameter int HDR_FIELDS = 23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        hdr_start,
  input  logic        hdr_enable,
  input  logic [63:0] hdr_val,
  input  logic [63:0] hdr_size,
  input  logic        hdr_flush,
  input  logic [31:0] Y_QMAT [8][8],
  input  logic [31:0] C_QMAT [8][8],
  input  logic        slice_valid,
  input  logic [63:0] slice_val,
  input  logic [63:0] slice_size,
  input  logic        slice_last,
  output logic        slice_ready,
  output logic        output_enable,
  output logic [63:0] val,
  output logic [63:0] size_of_bit,
  output logic        flush_bit,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] total_bits
);

  typedef enum logic [2:0] {
    IDLE, HEADER, QMAT_Y, QMAT_C, SLICE, FLUSH, DONE
  } state_t;

  localparam int MAXC = (HDR_FIELDS > 64) ? HDR_FIELDS : 64;
  localparam int CW = $clog2(MAXC) + 1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          beat_en, beat_flush, hs_n;
  logic [63:0]   beat_val, beat_size;
  logic [7:0]    qent;

  assign slice_ready = (state == SLICE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    beat_en    = 1'b0;
    beat_val   = '0;
    beat_size  = '0;
    beat_flush = 1'b0;
    hs_n       = 1'b0;
    qent       = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = HEADER;
          cnt_n   = '0;
          hs_n    = 1'b1;
        end
      end
      HEADER: begin
        if (hdr_enable) begin
          beat_en    = 1'b1;
          beat_val   = hdr_val;
          beat_size  = hdr_size;
          beat_flush = hdr_flush;
          if (cnt == CW'(HDR_FIELDS - 1)) begin
            cnt_n   = '0;
            state_n = QMAT_Y;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      QMAT_Y, QMAT_C: begin
        // cnt[5:3] is the row, cnt[2:0] the column
        if (state == QMAT_Y) qent = Y_QMAT[cnt[5:3]][cnt[2:0]][7:0];
        else                 qent = C_QMAT[cnt[5:3]][cnt[2:0]][7:0];
        beat_en   = 1'b1;
        beat_val  = {56'h0, qent};
        beat_size = 64'd8;
        if (cnt[5:0] == 6'd63) begin
          cnt_n   = '0;
          state_n = (state == QMAT_Y) ? QMAT_C : SLICE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SLICE: begin
        if (slice_valid) begin
          if (slice_size != 64'd0) begin
            beat_en   = 1'b1;
            beat_val  = slice_val;
            beat_size = slice_size;
          end
          if (slice_last) state_n = FLUSH;
        end
      end
      FLUSH: begin
        beat_en    = 1'b1;
        beat_flush = 1'b1;
        state_n    = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      hdr_start     <= 1'b0;
      output_enable <= 1'b0;
      val           <= '0;
      size_of_bit   <= '0;
      flush_bit     <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      hdr_start     <= hs_n;
      output_enable <= beat_en;
      val           <= beat_val;
      size_of_bit   <= beat_size;
      flush_bit     <= beat_flush;
      busy          <= (state_n != IDLE);
      frame_done    <= (state == DONE);
    end
  end

`ifdef FRAME_SEQ_BITCOUNT_EN
  logic [31:0] acc;
  logic [32:0] sum;
  assign sum = {1'b0, acc} + {1'b0, beat_size[31:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        acc <= '0;
    else if (hs_n)    acc <= '0;
    else if (beat_en) acc <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  end

  assign total_bits = acc;
`else
  assign total_bits = '0;
`endif

  // Only the low byte of each matrix entry carries data
  logic [63:0] unused_y, unused_c;
  for (genvar i = 0; i < 64; i++) begin : g_unused
    assign unused_y[i] = ^Y_QMAT[i / 8][i % 8][31:8];
    assign unused_c[i] = ^C_QMAT[i / 8][i % 8][31:8];
  end
  logic unused_hi;
  assign unused_hi = ^{unused_y, unused_c};

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: directed and randomized frames
// against a beat-list / running-sum reference model.
module tb_frame_sequencer;

  localparam int HDR = 23;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        hdr_start;
  logic        hdr_enable;
  logic [63:0] hdr_val;
  logic [63:0] hdr_size;
  logic        hdr_flush;
  logic [31:0] yq [8][8];
  logic [31:0] cq [8][8];
  logic        slice_valid;
  logic [63:0] slice_val;
  logic [63:0] slice_size;
  logic        slice_last;
  logic        slice_ready;
  logic        output_enable;
  logic [63:0] val;
  logic [63:0] size_of_bit;
  logic        flush_bit;
  logic        busy;
  logic        frame_done;
  logic [31:0] total_bits;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] model_sum;

  frame_sequencer #(.HDR_FIELDS(HDR)) dut (
    .clock(clock), .reset(reset), .start(start), .hdr_start(hdr_start),
    .hdr_enable(hdr_enable), .hdr_val(hdr_val), .hdr_size(hdr_size),
    .hdr_flush(hdr_flush), .Y_QMAT(yq), .C_QMAT(cq),
    .slice_valid(slice_valid), .slice_val(slice_val),
    .slice_size(slice_size), .slice_last(slice_last),
    .slice_ready(slice_ready), .output_enable(output_enable), .val(val),
    .size_of_bit(size_of_bit), .flush_bit(flush_bit), .busy(busy),
    .frame_done(frame_done), .total_bits(total_bits)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmp(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_total();
`ifdef FRAME_SEQ_BITCOUNT_EN
    return (model_sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : model_sum;
`else
    return 64'd0;
`endif
  endfunction

  task automatic check_out(string tag, logic en, logic [63:0] v,
                           logic [63:0] s, logic f);
    if (en) model_sum += {32'h0, s[31:0]};
    cmp({tag, ".en"}, output_enable, en);
    cmp({tag, ".val"}, val, v);
    cmp({tag, ".size"}, size_of_bit, s);
    cmp({tag, ".flush"}, flush_bit, f);
    cmp({tag, ".total"}, total_bits, exp_total());
  endtask

  // mode 0: directed, 1: random, 2: saturating sizes, 3: reset mid-QMAT_Y
  task automatic run_frame(input int mode);
    logic        gap, f, lst;
    logic [63:0] v, s;
    logic [31:0] e;
    int          n;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        yq[r][c] = $urandom;
        cq[r][c] = $urandom;
      end
    if (mode == 0) yq[0][1] = 32'h104;

    start = 1'b1;
    tick();
    start = 1'b0;
    model_sum = '0;
    cmp("hdr_start", hdr_start, 1);
    cmp("busy_hdr", busy, 1);
    check_out("after_start", 0, 0, 0, 0);

    for (int i = 0; i < HDR;) begin
      gap = (mode == 1) && ($urandom_range(0, 3) == 0);
      v = {$urandom, $urandom};
      f = 1'($urandom_range(0, 1));
      if (mode == 0)      s = 64'd32;
      else if (mode == 2) s = 64'h1_F000_0000 | 64'($urandom);
      else                s = 64'($urandom_range(0, 4000));
      hdr_enable = ~gap;
      hdr_val = v;
      hdr_size = s;
      hdr_flush = f;
      tick();
      cmp("hdr_start_pulse", hdr_start, 0);
      if (gap) check_out("hdr_gap", 0, 0, 0, 0);
      else begin
        check_out("hdr_beat", 1, v, s, f);
        i++;
      end
    end
    hdr_enable = 1'b0;

    for (int k = 0; k < 128; k++) begin
      hdr_enable = 1'($urandom_range(0, 1));
      hdr_val = {$urandom, $urandom};
      slice_valid = 1'b1;
      slice_last = 1'b1;
      slice_size = 64'd5;
      cmp("ready_qmat", slice_ready, 0);
      if (mode == 3 && k == 9) begin
        reset = 1'b1;
        #1;
        model_sum = '0;
        check_out("rst_mid", 0, 0, 0, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_hs", hdr_start, 0);
        cmp("rst_done", frame_done, 0);
        tick();
        reset = 1'b0;
        hdr_enable = 1'b0;
        slice_valid = 1'b0;
        slice_last = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          check_out("post_rst", 0, 0, 0, 0);
          cmp("post_rst_busy", busy, 0);
          cmp("post_rst_hs", hdr_start, 0);
        end
        return;
      end
      tick();
      e = (k < 64) ? yq[k / 8][k % 8] : cq[(k - 64) / 8][(k - 64) % 8];
      check_out("qmat", 1, {56'h0, e[7:0]}, 8, 0);
      if (mode == 0 && k == 1) cmp("qmat_y01", val, 64'h04);
    end
    hdr_enable = 1'b0;
    slice_valid = 1'b0;
    slice_last = 1'b0;

    if (mode == 0) begin
      for (int j = 0; j < 3; j++) begin
        slice_valid = 1'b1;
        slice_size = 64'd0;
        slice_val = {$urandom, $urandom};
        start = 1'b1;
        cmp("ready_hold", slice_ready, 1);
        tick();
        check_out("hold", 0, 0, 0, 0);
        cmp("hold_busy", busy, 1);
        cmp("hold_hs", hdr_start, 0);
      end
      start = 1'b0;
      slice_valid = 1'b0;
    end

    n = (mode == 0) ? 3 : $urandom_range(1, 6);
    for (int j = 0; j < n;) begin
      gap = (mode == 1) && ($urandom_range(0, 2) == 0);
      v = {$urandom, $urandom};
      if (mode == 0)
        s = (j == 0) ? 64'd100 : (j == 1) ? 64'd0 : 64'd50;
      else if ($urandom_range(0, 3) == 0)
        s = 64'd0;
      else
        s = 64'($urandom_range(1, 5000));
      lst = (j == n - 1);
      slice_valid = ~gap;
      slice_val = v;
      slice_size = s;
      slice_last = lst;
      cmp("ready_slice", slice_ready, 1);
      tick();
      if (gap || s == 0) check_out("slice_none", 0, 0, 0, 0);
      else check_out("slice_beat", 1, v, s, 0);
      if (!gap) j++;
    end
    slice_valid = 1'b0;
    slice_last = 1'b0;

    cmp("ready_flush", slice_ready, 0);
    tick();
    check_out("flush", 1, 0, 0, 1);
    cmp("flush_busy", busy, 1);
    cmp("flush_done", frame_done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_out("done_cyc", 0, 0, 0, 0);
    cmp("frame_done", frame_done, 1);
    cmp("done_busy", busy, 0);
    tick();
    check_out("idle_hold", 0, 0, 0, 0);
    cmp("done_pulse_end", frame_done, 0);
    cmp("start_in_done", hdr_start, 0);
    cmp("idle_busy", busy, 0);
    if (mode == 0) begin
`ifdef FRAME_SEQ_BITCOUNT_EN
      cmp("total_1910", total_bits, 64'd1910);
`else
      cmp("total_off", total_bits, 64'd0);
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hdr_enable = 1'b0;
    hdr_val = '0;
    hdr_size = '0;
    hdr_flush = 1'b0;
    slice_valid = 1'b0;
    slice_val = '0;
    slice_size = '0;
    slice_last = 1'b0;
    model_sum = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        yq[r][c] = '0;
        cq[r][c] = '0;
      end
    tick();
    tick();
    check_out("reset", 0, 0, 0, 0);
    cmp("reset_busy", busy, 0);
    cmp("reset_hs", hdr_start, 0);
    cmp("reset_done", frame_done, 0);
    cmp("reset_ready", slice_ready, 0);
    reset = 1'b0;
    tick();

    hdr_enable = 1'b1;
    hdr_size = 64'd77;
    hdr_val = 64'h1234;
    slice_valid = 1'b1;
    cmp("idle_ready", slice_ready, 0);
    tick();
    check_out("idle_hdr", 0, 0, 0, 0);
    cmp("idle_hdr_busy", busy, 0);
    hdr_enable = 1'b0;
    slice_valid = 1'b0;

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(0);
    run_frame(1);
    run_frame(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
